// File: rtl/g_aetcam_write_ctrl_if.sv
// Host-side handshake bundle for the TCAM write controller.
// Requests arrive as (op, key, mask, idx); responses return as (status, idx).
interface g_aetcam_write_ctrl_if #(
  parameter int WIDTH = 16,
  parameter int IDX_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic             req_op;
  logic [WIDTH-1:0] req_key;
  logic [WIDTH-1:0] req_mask;
  logic [IDX_W:0]   req_idx;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [1:0]       rsp_status;
  logic [IDX_W-1:0] rsp_idx;

  modport master (
    output req_valid, req_op, req_key, req_mask, req_idx, rsp_ready,
    input  req_ready, rsp_valid, rsp_status, rsp_idx
  );

  modport slave (
    input  req_valid, req_op, req_key, req_mask, req_idx, rsp_ready,
    output req_ready, rsp_valid, rsp_status, rsp_idx
  );
endinterface

// File: rtl/g_aetcam_write_ctrl.sv
// Write-side controller for a St/M ternary CAM.
// Inserts go to the lowest free row; deletes clear a row and its valid bit.
// Optional macro G_AETCAM_DUP_CHECK_EN adds shadow (st, mask) storage so that
// re-inserting an already valid rule returns DUP instead of taking a new row.
module g_aetcam_write_ctrl #(
  parameter  int DEPTH = 32,
  parameter  int WIDTH = 16,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  g_aetcam_write_ctrl_if.slave   bus,
  output logic [DEPTH-1:0]       cam_wen,
  output logic [WIDTH-1:0]       cam_w_st,
  output logic [WIDTH-1:0]       cam_w_m,
  output logic [DEPTH-1:0]       entry_valid,
  output logic [IDX_W:0]         count,
  output logic                   full
);

  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_WRITE, S_RESP} state_t;

  localparam logic [1:0]     ST_OK   = 2'b00;
  localparam logic [1:0]     ST_FULL = 2'b01;
  localparam logic [1:0]     ST_INV  = 2'b10;
  localparam logic [1:0]     ST_DUP  = 2'b11;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic               op_q;
  logic [WIDTH-1:0]   st_q, m_q;
  logic [IDX_W:0]     idx_q;
  logic [IDX_W-1:0]   tgt_q, tgt_d;
  logic [1:0]         status_q, status_d;
  logic [DEPTH-1:0]   valid_q;
  logic [IDX_W:0]     count_q;
  logic [IDX_W-1:0]   alloc_idx;
  logic               dup_hit;
  logic [IDX_W-1:0]   dup_idx;
  logic               del_ok;
  logic               full_w;
  logic               wr;

  assign full_w = (count_q == DEPTH_L);
  assign del_ok = (idx_q < DEPTH_L) && valid_q[idx_q[IDX_W-1:0]];

  // Lowest free row: scan downwards so the last hit is the smallest index.
  always_comb begin
    alloc_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (!valid_q[i]) alloc_idx = IDX_W'(i);
  end

`ifdef G_AETCAM_DUP_CHECK_EN
  logic [WIDTH-1:0] sh_st [DEPTH];
  logic [WIDTH-1:0] sh_m  [DEPTH];

  // Shadow copy of each inserted rule; stale rows are masked by valid_q.
  always_ff @(posedge clk) begin
    if (state_q == S_WRITE && !op_q) begin
      sh_st[tgt_q] <= st_q;
      sh_m[tgt_q]  <= m_q;
    end
  end

  // Match the pending normalised rule against all valid rows, lowest wins.
  always_comb begin
    dup_hit = 1'b0;
    dup_idx = '0;
    for (int i = DEPTH-1; i >= 0; i--)
      if (valid_q[i] && sh_st[i] == st_q && sh_m[i] == m_q) begin
        dup_hit = 1'b1;
        dup_idx = IDX_W'(i);
      end
  end
`else
  assign dup_hit = 1'b0;
  assign dup_idx = '0;
`endif

  // Next-state and CHECK-time decisions (target row and response status).
  always_comb begin
    state_d  = state_q;
    tgt_d    = tgt_q;
    status_d = status_q;
    case (state_q)
      S_IDLE:  if (bus.req_valid) state_d = S_CHECK;
      S_CHECK: begin
        if (!op_q) begin
          if (dup_hit) begin
            state_d = S_RESP; status_d = ST_DUP;  tgt_d = dup_idx;
          end else if (full_w) begin
            state_d = S_RESP; status_d = ST_FULL; tgt_d = '0;
          end else begin
            state_d = S_WRITE; status_d = ST_OK;  tgt_d = alloc_idx;
          end
        end else if (del_ok) begin
          state_d = S_WRITE; status_d = ST_OK;  tgt_d = idx_q[IDX_W-1:0];
        end else begin
          state_d = S_RESP;  status_d = ST_INV; tgt_d = '0;
        end
      end
      S_WRITE: state_d = S_RESP;
      S_RESP:  if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM state plus the registered decision fields.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      tgt_q    <= '0;
      status_q <= ST_OK;
    end else begin
      state_q  <= state_d;
      tgt_q    <= tgt_d;
      status_q <= status_d;
    end
  end

  // Request capture and per-row validity bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q    <= 1'b0;
      st_q    <= '0;
      m_q     <= '0;
      idx_q   <= '0;
      valid_q <= '0;
      count_q <= '0;
    end else begin
      if (state_q == S_IDLE && bus.req_valid) begin
        op_q  <= bus.req_op;
        st_q  <= bus.req_key & ~bus.req_mask;
        m_q   <= bus.req_mask;
        idx_q <= bus.req_idx;
      end
      if (state_q == S_WRITE) begin
        valid_q[tgt_q] <= !op_q;
        count_q        <= op_q ? count_q - 1'b1 : count_q + 1'b1;
      end
    end
  end

  // Outputs are gated by rst so nothing leaks while reset is asserted.
  assign wr             = (state_q == S_WRITE) && !rst;
  assign bus.req_ready  = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid  = (state_q == S_RESP) && !rst;
  assign bus.rsp_status = bus.rsp_valid ? status_q : 2'b00;
  assign bus.rsp_idx    = bus.rsp_valid ? tgt_q : '0;
  assign cam_wen        = wr ? ({{(DEPTH-1){1'b0}}, 1'b1} << tgt_q) : '0;
  assign cam_w_st       = (wr && !op_q) ? st_q : '0;
  assign cam_w_m        = (wr && !op_q) ? m_q  : '0;
  assign entry_valid    = valid_q;
  assign count          = count_q;
  assign full           = full_w;

endmodule

// File: tb/tb_g_aetcam_write_ctrl.sv
// Scoreboard bench for g_aetcam_write_ctrl: the driver pushes expected writes
// and responses; a negedge monitor pops and compares them as the DUT emits.
module tb_g_aetcam_write_ctrl;
  localparam int DEPTH = 32;
  localparam int WIDTH = 16;
  localparam int IDX_W = 5;
  localparam logic [1:0] OK = 2'b00, FULLS = 2'b01, INV = 2'b10, DUP = 2'b11;

  typedef struct { logic [1:0] status; logic [IDX_W-1:0] idx; int cyc; } rsp_t;
  typedef struct { logic [DEPTH-1:0] wen; logic [WIDTH-1:0] st; logic [WIDTH-1:0] m; int cyc; } wr_t;

  logic clk = 1'b0;
  logic rst;
  logic [DEPTH-1:0] cam_wen, entry_valid;
  logic [WIDTH-1:0] cam_w_st, cam_w_m;
  logic [IDX_W:0]   count;
  logic             full;

  g_aetcam_write_ctrl_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus();

  g_aetcam_write_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .cam_wen(cam_wen), .cam_w_st(cam_w_st), .cam_w_m(cam_w_m),
    .entry_valid(entry_valid), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Monitor: compare every write pulse and every response cycle to the queues.
  logic prev_rsp_valid = 1'b0;
  always @(negedge clk) begin
    if (cam_wen != '0) begin
      if (wr_q.size() == 0) fail("unexpected_cam_wen");
      else begin
        wr_t w;
        w = wr_q.pop_front();
        chk("cam_wen", cam_wen, w.wen);
        chk("cam_w_st", 32'(cam_w_st), 32'(w.st));
        chk("cam_w_m", 32'(cam_w_m), 32'(w.m));
        chk("wen_latency", cyc, w.cyc);
      end
    end else begin
      chk("w_data_idle", {cam_w_st, cam_w_m}, 32'h0);
    end
    if (bus.rsp_valid) begin
      if (rsp_q.size() == 0) fail("unexpected_rsp");
      else begin
        rsp_t r;
        r = rsp_q[0];
        chk("rsp_status", 32'(bus.rsp_status), 32'(r.status));
        chk("rsp_idx", 32'(bus.rsp_idx), 32'(r.idx));
        if (!prev_rsp_valid && r.cyc >= 0) chk("rsp_latency", cyc, r.cyc);
        if (bus.rsp_ready) void'(rsp_q.pop_front());
      end
    end
    prev_rsp_valid = bus.rsp_valid;
  end

  // Issue one request; expectations are pushed before the accepting edge.
  task automatic issue(input logic op, input logic [WIDTH-1:0] key, input logic [WIDTH-1:0] mask,
                       input logic [IDX_W:0] idx, input logic [1:0] est, input int eidx,
                       input bit do_wr, input bit lat);
    int n;
    int acc;
    rsp_t r;
    wr_t  w;
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = op; bus.req_key = key;
    bus.req_mask = mask; bus.req_idx = idx;
    n = 0;
    @(negedge clk);
    while (!bus.req_ready && n < 100) begin n++; @(negedge clk); end
    if (n >= 100) fail("req_ready_timeout");
    acc = cyc;
    if (do_wr) begin
      w.wen = 32'h1 << eidx;
      w.st  = op ? '0 : (key & ~mask);
      w.m   = op ? '0 : mask;
      w.cyc = acc + 2;
      wr_q.push_back(w);
    end
    r.status = est;
    r.idx    = IDX_W'(eidx);
    r.cyc    = lat ? (do_wr ? acc + 3 : acc + 2) : -1;
    rsp_q.push_back(r);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (!(bus.req_ready && !bus.rsp_valid && rsp_q.size() == 0 && wr_q.size() == 0) && n < 200) begin
      n++; @(negedge clk);
    end
    if (n >= 200) fail("idle_timeout");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.req_key = '0;
    bus.req_mask = '0; bus.req_idx = '0; bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    chk("rst_rsp_fields", {bus.rsp_status, bus.rsp_idx}, 0);
    chk("rst_cam_wen", cam_wen, 0);
    chk("rst_entry_valid", entry_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);

    // 1: first insert, key normalised by mask
    issue(1'b0, 16'h00A5, 16'h000F, 0, OK, 0, 1, 1);
    wait_idle();
    chk("t1_count", count, 1);
    chk("t1_valid", entry_valid, 32'h1);

    // 2: fill the table in index order, then overflow
    for (int i = 1; i < DEPTH; i++) issue(1'b0, 16'h1000 + 16'(i), 16'h0, 0, OK, i, 1, 1);
    wait_idle();
    chk("t2_count", count, 32);
    chk("t2_full", full, 1);
    chk("t2_valid", entry_valid, 32'hFFFF_FFFF);
    issue(1'b0, 16'h5555, 16'h0, 0, FULLS, 0, 0, 1);
    wait_idle();
    chk("t2_count_after_full", count, 32);

    // 3: delete 5 from full, then refill it
    issue(1'b1, 16'h0, 16'h0, 5, OK, 5, 1, 1);
    wait_idle();
    chk("t3_full_clr", full, 0);
    chk("t3_count", count, 31);
    chk("t3_valid", entry_valid, 32'hFFFF_FFDF);
    issue(1'b0, 16'h2222, 16'h0, 0, OK, 5, 1, 1);
    wait_idle();
    chk("t3_full_set", full, 1);

    // 4: invalid deletes (empty row, out of range)
    issue(1'b1, 16'h0, 16'h0, 7, OK, 7, 1, 1);
    issue(1'b1, 16'h0, 16'h0, 7, INV, 0, 0, 1);
    issue(1'b1, 16'h0, 16'h0, 40, INV, 0, 0, 1);
    wait_idle();
    chk("t4_count", count, 31);
    chk("t4_valid", entry_valid, 32'hFFFF_FF7F);

    // 6a: reset while in WRITE discards the op
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = 1'b0; bus.req_key = 16'h7777; bus.req_mask = 16'h0;
    @(negedge clk);
    chk("t6_ready", bus.req_ready, 1);
    @(posedge clk); #1 bus.req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_valid", entry_valid, 0);
    chk("t6_count", count, 0);
    chk("t6_full", full, 0);
    chk("t6_rsp_valid", bus.rsp_valid, 0);
    chk("t6_req_ready", bus.req_ready, 1);

    // 6b: response held while rsp_ready is low
    @(posedge clk); #1 bus.rsp_ready = 1'b0;
    issue(1'b0, 16'h00C3, 16'h0003, 0, OK, 0, 1, 0);
    repeat (6) @(negedge clk);
    chk("t6_rsp_hold", bus.rsp_valid, 1);
    @(posedge clk); #1 bus.rsp_ready = 1'b1;
    wait_idle();
    chk("t6_count_after", count, 1);

    // 5: duplicate rule insert
    issue(1'b0, 16'h1234, 16'h00FF, 0, OK, 1, 1, 1);
`ifdef G_AETCAM_DUP_CHECK_EN
    issue(1'b0, 16'h1234, 16'h00FF, 0, DUP, 1, 0, 1);
    wait_idle();
    chk("t5_count", count, 2);
`else
    issue(1'b0, 16'h1234, 16'h00FF, 0, OK, 2, 1, 1);
    wait_idle();
    chk("t5_count", count, 3);
`endif

    wait_idle();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
